// File: rtl/frame_pixel_streamer_pkg.sv
// Shared defaults, FSM encodings and marker bundle for the pixel-stream transmit side.
package frame_pixel_streamer_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_W      = 640;
    localparam int DEF_IMG_H      = 480;
    localparam int DEF_H_BLANK    = 4;
    localparam int DEF_ADDR_WIDTH = 19;

    // Cycles between the last RAM read and the last emitted pixel.
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_HBLANK = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } mark_t;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Column/row/linear-address counters for a raster scan; advances once per RAM read.
module frame_addr_counter
    import frame_pixel_streamer_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  first_pix,
    output logic                  last_col,
    output logic                  last_pix
);

    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    assign first_pix = (col == '0) && (row == '0);
    assign last_col  = (col == COL_W'(IMG_W - 1));
    assign last_pix  = last_col && (row == ROW_W'(IMG_H - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (inc) begin
            addr <= addr + 1'b1;
            if (last_col) begin
                col <= '0;
                row <= last_pix ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_pixel_streamer.sv
// Streams one raster frame from a 1-cycle synchronous RAM as a pixel stream with
// row blanking and sof/eol/eof markers.
module frame_pixel_streamer
    import frame_pixel_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int H_BLANK    = DEF_H_BLANK,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_en,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof
);

    localparam int CNT_W = cnt_width((H_BLANK > DRAIN_CYCLES) ? H_BLANK : DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             first_pix, last_col, last_pix;
    logic             vld_s1;
    mark_t            mark_s0, mark_s1;

    frame_addr_counter #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr (
        .clk       (clk),
        .rst       (rst),
        .clr       ((state == ST_IDLE) && start),
        .inc       (mem_rd_en),
        .addr      (mem_addr),
        .first_pix (first_pix),
        .last_col  (last_col),
        .last_pix  (last_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ACTIVE;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (last_pix) begin
                        state     <= ST_DRAIN;
                        mem_rd_en <= 1'b0;
                        cnt       <= '0;
                    end else if (last_col && (H_BLANK > 0)) begin
                        state     <= ST_HBLANK;
                        mem_rd_en <= 1'b0;
                        cnt       <= '0;
                    end
                end
                ST_HBLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state     <= ST_ACTIVE;
                        mem_rd_en <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Wait for the last read to leave the output pipe.
                    if (cnt == DRAIN_LAST) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Markers are qualified by the read strobe so they ride the same pipe as the data.
    assign mark_s0 = {mem_rd_en & first_pix, mem_rd_en & last_col, mem_rd_en & last_pix};

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_s1      <= 1'b0;
            mark_s1     <= '0;
            data_out    <= '0;
            data_out_en <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
        end else begin
            vld_s1      <= mem_rd_en;
            mark_s1     <= mark_s0;
            data_out_en <= vld_s1;
            sof         <= mark_s1.sof;
            eol         <= mark_s1.eol;
            eof         <= mark_s1.eof;
            if (vld_s1) begin
                data_out <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Scoreboard bench: three streamer configurations fed from a RAM holding mem[i]=i[7:0].
module tb_frame_pixel_streamer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HB = 2;
    localparam int CW = 64;
    localparam int CH = 48;
    localparam int CHB = 4;
    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic          busy_a, done_a, rd_en_a, en_a, sof_a, eol_a, eof_a;
    logic [AW-1:0] addr_a;
    logic [7:0]    rd_data_a, dout_a;
    logic          busy_b, done_b, rd_en_b, en_b, sof_b, eol_b, eof_b;
    logic [AW-1:0] addr_b;
    logic [7:0]    rd_data_b, dout_b;
    logic          busy_c, done_c, rd_en_c, en_c, sof_c, eol_c, eof_c;
    logic [AW-1:0] addr_c;
    logic [7:0]    rd_data_c, dout_c;

    logic [7:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1<<AW); i++) mem[i] = i[7:0];

    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem[addr_a];
        if (rd_en_b) rd_data_b <= mem[addr_b];
        if (rd_en_c) rd_data_c <= mem[addr_c];
    end

    frame_pixel_streamer #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H), .H_BLANK(HB), .ADDR_WIDTH(AW)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_rd_data(rd_data_a),
        .data_out(dout_a), .data_out_en(en_a), .sof(sof_a), .eol(eol_a), .eof(eof_a));

    frame_pixel_streamer #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H), .H_BLANK(0), .ADDR_WIDTH(AW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_data(rd_data_b),
        .data_out(dout_b), .data_out_en(en_b), .sof(sof_b), .eol(eol_b), .eof(eof_b));

    frame_pixel_streamer #(.DATA_WIDTH(8), .IMG_W(CW), .IMG_H(CH), .H_BLANK(CHB), .ADDR_WIDTH(AW)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .mem_rd_en(rd_en_c), .mem_addr(addr_c), .mem_rd_data(rd_data_c),
        .data_out(dout_c), .data_out_en(en_c), .sof(sof_c), .eol(eol_c), .eof(eof_c));

    typedef struct {
        logic [7:0] data;
        int         cyc;
        logic       sof, eol, eof;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Expected output stream: pixel (r,c) appears 3 + r*(w+hb) + c cycles after start.
    task automatic push_frame(input int w, input int h, input int hb, input int base);
        for (int p = 0; p < w*h; p++) begin
            exp_t e;
            int   r, c;
            r = p / w;
            c = p % w;
            e.data = p[7:0];
            e.cyc  = base + 3 + r*(w+hb) + c;
            e.sof  = (p == 0);
            e.eol  = (c == w-1);
            e.eof  = (p == w*h-1);
            sb.push_back(e);
        end
    endtask

    // Is a RAM read expected at this cycle (relative to start) for config A?
    function automatic bit exp_rd(input int rel);
        int k;
        k = rel - 1;
        return (rel >= 1) && ((k / (W+HB)) < H) && ((k % (W+HB)) < W);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy_a, done_a, rd_en_a, en_a, sof_a, eol_a, eof_a, |addr_a, |dout_a} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_a: outputs=%b required 0", {busy_a, done_a, rd_en_a, en_a, sof_a, eol_a, eof_a, |addr_a, |dout_a});
        end
        n_cmp++;
        if ({busy_b, done_b, rd_en_b, en_b, busy_c, done_c, rd_en_c, en_c} !== 8'b0) begin
            n_bad++;
            $display("FAIL reset_bc: outputs=%b required 0", {busy_b, done_b, rd_en_b, en_b, busy_c, done_c, rd_en_c, en_c});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy_a, rd_en_a, en_a} !== 3'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy/rd/en=%b required 000", {busy_a, rd_en_a, en_a});
        end
    endtask

    task automatic test_frame_markers();
        sb.delete();
        push_frame(W, H, HB, 0);
        @(posedge clk); #1 start_a = 1'b1;
        for (int r = 0; r <= 22; r++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy_a, done_a, rd_en_a, en_a} !== {(r >= 1 && r <= 19), (r == 19), exp_rd(r), exp_rd(r-2)}) begin
                n_bad++;
                $display("FAIL frame_ctl cyc %0d: busy/done/rd/en=%b required %b", r,
                         {busy_a, done_a, rd_en_a, en_a}, {(r >= 1 && r <= 19), (r == 19), exp_rd(r), exp_rd(r-2)});
            end
            if (rd_en_a && exp_rd(r)) begin
                n_cmp++;
                if (int'(addr_a) != ((r-1)/(W+HB))*W + (r-1)%(W+HB)) begin
                    n_bad++;
                    $display("FAIL frame_addr cyc %0d: addr=%0d required %0d", r, addr_a, ((r-1)/(W+HB))*W + (r-1)%(W+HB));
                end
            end
            if (en_a) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_extra cyc %0d: unexpected pixel %0d", r, dout_a);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.cyc != r || dout_a !== e.data || {sof_a, eol_a, eof_a} !== {e.sof, e.eol, e.eof}) begin
                        n_bad++;
                        $display("FAIL frame_pix cyc %0d: data=%0d marks=%b required cyc %0d data=%0d marks=%b",
                                 r, dout_a, {sof_a, eol_a, eof_a}, e.cyc, e.data, {e.sof, e.eol, e.eof});
                    end
                end
            end else begin
                n_cmp++;
                if ({sof_a, eol_a, eof_a} !== 3'b0) begin
                    n_bad++;
                    $display("FAIL marks_idle cyc %0d: marks=%b required 000", r, {sof_a, eol_a, eof_a});
                end
            end
            @(posedge clk); #1 start_a = 1'b0;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL frame_missing: %0d pixels not seen required 0", sb.size());
        end
    endtask

    task automatic test_start_ignored();
        sb.delete();
        push_frame(W, H, HB, 0);
        push_frame(W, H, HB, 21);
        @(posedge clk); #1 start_a = 1'b1;
        for (int r = 0; r <= 44; r++) begin
            logic [2:0] e3;
            @(negedge clk);
            e3 = {((r >= 1 && r <= 19) || (r >= 22 && r <= 40)), (r == 19 || r == 40), (exp_rd(r-2) || exp_rd(r-23))};
            n_cmp++;
            if ({busy_a, done_a, en_a} !== e3) begin
                n_bad++;
                $display("FAIL start_ign cyc %0d: busy/done/en=%b required %b", r, {busy_a, done_a, en_a}, e3);
            end
            if (r == 22) begin
                n_cmp++;
                if ({rd_en_a, addr_a} !== {1'b1, {AW{1'b0}}}) begin
                    n_bad++;
                    $display("FAIL restart_addr: rd_en=%b addr=%0d required 1 and 0", rd_en_a, addr_a);
                end
            end
            if (en_a && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != r || dout_a !== e.data || {sof_a, eol_a, eof_a} !== {e.sof, e.eol, e.eof}) begin
                    n_bad++;
                    $display("FAIL start_ign_pix cyc %0d: data=%0d marks=%b required cyc %0d data=%0d marks=%b",
                             r, dout_a, {sof_a, eol_a, eof_a}, e.cyc, e.data, {e.sof, e.eol, e.eof});
                end
            end
            @(posedge clk); #1 start_a = (r+1 == 5) || (r+1 == 19) || (r+1 == 21);
        end
        start_a = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL start_ign_missing: %0d pixels not seen required 0", sb.size());
        end
    endtask

    task automatic test_no_blank();
        sb.delete();
        push_frame(W, H, 0, 0);
        @(posedge clk); #1 start_b = 1'b1;
        for (int r = 0; r <= 18; r++) begin
            logic [2:0] e3;
            @(negedge clk);
            e3 = {(r >= 1 && r <= 15), (r == 15), (r >= 3 && r <= 14)};
            n_cmp++;
            if ({busy_b, done_b, en_b} !== e3) begin
                n_bad++;
                $display("FAIL noblank_ctl cyc %0d: busy/done/en=%b required %b", r, {busy_b, done_b, en_b}, e3);
            end
            if (en_b && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != r || dout_b !== e.data || {sof_b, eol_b, eof_b} !== {e.sof, e.eol, e.eof}) begin
                    n_bad++;
                    $display("FAIL noblank_pix cyc %0d: data=%0d marks=%b required cyc %0d data=%0d marks=%b",
                             r, dout_b, {sof_b, eol_b, eof_b}, e.cyc, e.data, {e.sof, e.eol, e.eof});
                end
            end
            @(posedge clk); #1 start_b = 1'b0;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL noblank_missing: %0d pixels not seen required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        sb.delete();
        @(posedge clk); #1 start_a = 1'b1;
        for (int r = 0; r <= 14; r++) begin
            @(negedge clk);
            if (r >= 9) begin
                n_cmp++;
                if ({busy_a, done_a, rd_en_a, en_a, sof_a, eol_a, eof_a, |addr_a, |dout_a} !== 9'b0) begin
                    n_bad++;
                    $display("FAIL rst_mid cyc %0d: outputs=%b required 0", r,
                             {busy_a, done_a, rd_en_a, en_a, sof_a, eol_a, eof_a, |addr_a, |dout_a});
                end
            end
            @(posedge clk); #1 start_a = 1'b0; rst = (r+1 == 8);
        end
        rst = 1'b0;
        push_frame(W, H, HB, 0);
        @(posedge clk); #1 start_a = 1'b1;
        for (int r = 0; r <= 22; r++) begin
            @(negedge clk);
            if (r == 1) begin
                n_cmp++;
                if ({rd_en_a, addr_a} !== {1'b1, {AW{1'b0}}}) begin
                    n_bad++;
                    $display("FAIL rst_restart_addr: rd_en=%b addr=%0d required 1 and 0", rd_en_a, addr_a);
                end
            end
            n_cmp++;
            if ({done_a, en_a} !== {(r == 19), exp_rd(r-2)}) begin
                n_bad++;
                $display("FAIL rst_restart_ctl cyc %0d: done/en=%b required %b", r, {done_a, en_a}, {(r == 19), exp_rd(r-2)});
            end
            if (en_a && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != r || dout_a !== e.data || {sof_a, eol_a, eof_a} !== {e.sof, e.eol, e.eof}) begin
                    n_bad++;
                    $display("FAIL rst_restart_pix cyc %0d: data=%0d marks=%b required cyc %0d data=%0d marks=%b",
                             r, dout_a, {sof_a, eol_a, eof_a}, e.cyc, e.data, {e.sof, e.eol, e.eof});
                end
            end
            @(posedge clk); #1 start_a = 1'b0;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL rst_restart_missing: %0d pixels not seen required 0", sb.size());
        end
    endtask

    task automatic test_large_frame();
        int en_cnt, eol_cnt, eof_cyc, done_cyc, r;
        en_cnt = 0; eol_cnt = 0; eof_cyc = -1; done_cyc = -1; r = 0;
        sb.delete();
        push_frame(CW, CH, CHB, 0);
        @(posedge clk); #1 start_c = 1'b1;
        while (done_cyc < 0 && r < 3600) begin
            @(negedge clk);
            if (en_c) begin
                en_cnt++;
                if (eol_c) eol_cnt++;
                if (eof_c) eof_cyc = r;
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    n_cmp++;
                    if (e.cyc != r || dout_c !== e.data || {sof_c, eol_c, eof_c} !== {e.sof, e.eol, e.eof}) begin
                        n_bad++;
                        $display("FAIL large_pix cyc %0d: data=%0d marks=%b required cyc %0d data=%0d marks=%b",
                                 r, dout_c, {sof_c, eol_c, eof_c}, e.cyc, e.data, {e.sof, e.eol, e.eof});
                    end
                end
            end
            if (done_c) done_cyc = r;
            @(posedge clk); #1 start_c = 1'b0;
            r++;
        end
        n_cmp++;
        if (done_cyc < 0) begin
            n_bad++;
            $display("FAIL large_timeout: no done within %0d cycles required done", r);
        end
        n_cmp++;
        if (en_cnt != CW*CH || eol_cnt != CH) begin
            n_bad++;
            $display("FAIL large_counts: en=%0d eol=%0d required en=%0d eol=%0d", en_cnt, eol_cnt, CW*CH, CH);
        end
        n_cmp++;
        if (done_cyc != eof_cyc + 1 || done_cyc != 3 + (CH-1)*(CW+CHB) + CW) begin
            n_bad++;
            $display("FAIL large_done: done at %0d eof at %0d required done at %0d", done_cyc, eof_cyc, 3 + (CH-1)*(CW+CHB) + CW);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL large_missing: %0d pixels not seen required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame_markers();
        test_start_ignored();
        test_no_blank();
        test_reset_mid();
        test_large_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
